// File: rtl/dac_pkg.sv
// Shared constants and types for the DAC channel scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: command/address codes driven to the DAC serial engine, the
// scheduler FSM state type, and default channel count / sample width.
package dac_pkg;

  // Command nibble for "write input register and update output".
  localparam logic [3:0] CMD_WR_UPD = 4'b0011;
  // Address code that makes the DAC engine write every channel at once.
  localparam logic [3:0] ADDR_ALL   = 4'b1111;

  localparam int NCH_DEF = 4;
  localparam int DW_DEF  = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dac_rr_arb.sv
// Round-robin channel picker: first set pending bit at or above rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
//
// Ports:
//   pend      in   NCH  pending request vector
//   rr_ptr    in   PW   index searched first
//   gnt_valid out  1    at least one bit of pend is set
//   gnt_idx   out  PW   granted channel index (0 when gnt_valid is low)
module dac_rr_arb
  import dac_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] pend,
  input  logic [PW-1:0]  rr_ptr,
  output logic           gnt_valid,
  output logic [PW-1:0]  gnt_idx
);

  logic [PW-1:0] idx;

  // Walk the offsets from the far end down to zero so the last hit written,
  // i.e. the one closest to rr_ptr, is the one that sticks.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NCH);
      if (pend[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/dac_sched.sv
// Mailbox scheduler serialising per-channel and broadcast DAC writes onto one engine.
// Latency: req at edge k -> selection at k+1 -> dactrig after k+2; done one edge after dacdone.
// Backpressure: none upstream; requests coalesce (last value wins), broadcast has priority.
//
// Ports:
//   CLK50MHZ, RST        clock, async active-low reset
//   req/req_data         per-channel write strobes and values (channel i at [i*DW +: DW])
//   bcast_req/bcast_data all-channel write strobe and value
//   clr_err              clears the sticky timeout flag
//   data/address/command write presented to the DAC engine, stable from ISSUE onward
//   dactrig/dacdone      one-cycle start / completion pulses with the engine
//   busy/done/done_addr  transaction status; done_addr valid with done
//   err                  sticky: engine failed to answer within TMO cycles
module dac_sched
  import dac_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  parameter int TMO = 4096
) (
  input  logic              CLK50MHZ,
  input  logic              RST,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] req_data,
  input  logic              bcast_req,
  input  logic [DW-1:0]     bcast_data,
  input  logic              clr_err,
  output logic [DW-1:0]     data,
  output logic [3:0]        address,
  output logic [3:0]        command,
  output logic              dactrig,
  input  logic              dacdone,
  output logic              busy,
  output logic              done,
  output logic [3:0]        done_addr,
  output logic              err
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;

  state_t          state, state_n;
  logic [NCH-1:0]  pend, pend_n;
  logic [DW-1:0]   val [NCH];
  logic [DW-1:0]   val_n [NCH];
  logic            pend_b, pend_b_n;
  logic [DW-1:0]   val_b, val_b_n;
  logic [PW-1:0]   rr_ptr, rr_ptr_n;
  logic [CW-1:0]   tmo_cnt, tmo_cnt_n;
  logic [DW-1:0]   data_n;
  logic [3:0]      address_n, done_addr_n;
  logic            dactrig_n, busy_n, done_n, err_n;
  logic            gnt_valid;
  logic [PW-1:0]   gnt_idx;
  logic            sel_b, tmo_hit;
  logic [NCH-1:0]  sel_ch;

  // The engine only ever receives write-and-update commands.
  assign command = CMD_WR_UPD;

  dac_rr_arb #(
    .NCH (NCH),
    .PW  (PW)
  ) u_arb (
    .pend      (pend),
    .rr_ptr    (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_n     = state;
    data_n      = data;
    address_n   = address;
    dactrig_n   = 1'b0;
    busy_n      = busy;
    done_n      = 1'b0;
    done_addr_n = done_addr;
    rr_ptr_n    = rr_ptr;
    tmo_cnt_n   = tmo_cnt;
    sel_b       = 1'b0;
    sel_ch      = '0;
    tmo_hit     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pend_b) begin
          sel_b     = 1'b1;
          data_n    = val_b;
          address_n = ADDR_ALL;
          busy_n    = 1'b1;
          tmo_cnt_n = '0;
          state_n   = ST_ISSUE;
        end else if (gnt_valid) begin
          sel_ch[gnt_idx] = 1'b1;
          data_n    = val[gnt_idx];
          address_n = 4'(gnt_idx);
          busy_n    = 1'b1;
          tmo_cnt_n = '0;
          state_n   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dactrig_n = 1'b1;
        state_n   = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion arriving on the last allowed cycle still counts.
        if (dacdone) begin
          state_n = ST_DONE;
        end else if (tmo_cnt == CW'(TMO - 1)) begin
          tmo_hit = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        done_n      = 1'b1;
        done_addr_n = address;
        busy_n      = 1'b0;
        state_n     = ST_IDLE;
        // Broadcasts do not move the fairness pointer.
        if (address != ADDR_ALL) begin
          rr_ptr_n = (address[PW-1:0] == PW'(NCH - 1)) ? '0 : address[PW-1:0] + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    err_n = tmo_hit ? 1'b1 : (clr_err ? 1'b0 : err);

    // Mailboxes: a fresh request always wins; a broadcast supersedes older
    // per-channel values; the selected source is consumed.
    pend_b_n = bcast_req | (pend_b & ~sel_b);
    val_b_n  = bcast_req ? bcast_data : val_b;
    for (int i = 0; i < NCH; i++) begin
      pend_n[i] = req[i] | (pend[i] & ~bcast_req & ~sel_ch[i]);
      val_n[i]  = req[i] ? req_data[i*DW +: DW] : val[i];
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      pend      <= '0;
      pend_b    <= 1'b0;
      val_b     <= '0;
      rr_ptr    <= '0;
      tmo_cnt   <= '0;
      data      <= '0;
      address   <= '0;
      dactrig   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_addr <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NCH; i++) val[i] <= '0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      pend_b    <= pend_b_n;
      val_b     <= val_b_n;
      rr_ptr    <= rr_ptr_n;
      tmo_cnt   <= tmo_cnt_n;
      data      <= data_n;
      address   <= address_n;
      dactrig   <= dactrig_n;
      busy      <= busy_n;
      done      <= done_n;
      done_addr <= done_addr_n;
      err       <= err_n;
      for (int i = 0; i < NCH; i++) val[i] <= val_n[i];
    end
  end

endmodule

// File: tb/tb_dac_sched.sv
// Bench for dac_sched: directed scenarios plus random traffic against a
// transaction-timed mailbox model; the bench also plays the DAC engine.
module tb_dac_sched;
  import dac_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int TMO = 64;

  logic              CLK50MHZ = 1'b0;
  logic              RST;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] req_data;
  logic              bcast_req;
  logic [DW-1:0]     bcast_data;
  logic              clr_err;
  logic [DW-1:0]     data;
  logic [3:0]        address, command, done_addr;
  logic              dactrig, dacdone, busy, done, err;

  dac_sched #(.NCH(NCH), .DW(DW), .TMO(TMO)) dut (
    .CLK50MHZ   (CLK50MHZ),
    .RST        (RST),
    .req        (req),
    .req_data   (req_data),
    .bcast_req  (bcast_req),
    .bcast_data (bcast_data),
    .clr_err    (clr_err),
    .data       (data),
    .address    (address),
    .command    (command),
    .dactrig    (dactrig),
    .dacdone    (dacdone),
    .busy       (busy),
    .done       (done),
    .done_addr  (done_addr),
    .err        (err)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  int n_chk = 0;
  int n_err = 0;

  // stimulus knobs (strobes auto-clear after each cycle)
  bit            rq [NCH];
  logic [DW-1:0] rv [NCH];
  bit            bq, ce, spur, hold;
  logic [DW-1:0] bv;
  int            lat = 3;
  int            ack_at = -1000;
  int            cyc = 0;
  int            t0;

  // reference model: mailboxes plus the timestamps of the transaction in flight
  bit            m_pend [NCH];
  logic [DW-1:0] m_val [NCH];
  bit            m_pb;
  logic [DW-1:0] m_vb;
  int            m_rr;
  bit            m_active;
  int            sel_edge, ack_edge;
  logic [3:0]    e_addr, e_daddr;
  logic [DW-1:0] e_data;
  bit            e_trig, e_busy, e_done, e_err;

  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int          obs_t[$];
  logic [3:0]  dn_q[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) begin
      m_pend[i] = 1'b0;
      m_val[i]  = '0;
    end
    m_pb = 0; m_vb = '0; m_rr = 0; m_active = 0;
    e_addr = '0; e_daddr = '0; e_data = '0;
    e_trig = 0; e_busy = 0; e_done = 0; e_err = 0;
  endtask

  // One clock edge of the scheduler's rules, expressed as "when does each
  // event of the current transaction happen relative to its selection".
  task automatic model_edge();
    bit tmo;
    int pick;
    tmo = 0; pick = -1;
    e_trig = 0; e_done = 0;
    if (m_active) begin
      if (ack_edge < 0 && cyc >= sel_edge + 2 && dacdone) ack_edge = cyc;
      if (ack_edge >= 0 && cyc == ack_edge + 1) begin
        e_done = 1; e_daddr = e_addr; e_busy = 0; m_active = 0;
        if (e_addr != ADDR_ALL) m_rr = (e_addr + 1) % NCH;
      end else if (ack_edge < 0 && cyc == sel_edge + 1 + TMO) begin
        tmo = 1; e_busy = 0; m_active = 0;
      end else if (cyc == sel_edge + 1) begin
        e_trig = 1;
      end
    end else begin
      if (m_pb) pick = NCH;
      else
        for (int k = 0; k < NCH; k++)
          if (pick < 0 && m_pend[(m_rr + k) % NCH]) pick = (m_rr + k) % NCH;
      if (pick >= 0) begin
        m_active = 1; sel_edge = cyc; ack_edge = -1; e_busy = 1;
        if (pick == NCH) begin
          e_addr = ADDR_ALL; e_data = m_vb; m_pb = 0;
        end else begin
          e_addr = 4'(pick); e_data = m_val[pick]; m_pend[pick] = 0;
        end
      end
    end
    if (tmo) e_err = 1;
    else if (ce) e_err = 0;
    if (bq) begin
      m_pb = 1; m_vb = bv;
      foreach (m_pend[i]) m_pend[i] = 0;
    end
    foreach (rq[i]) if (rq[i]) begin
      m_pend[i] = 1; m_val[i] = rv[i];
    end
  endtask

  task automatic step();
    req        = {rq[3], rq[2], rq[1], rq[0]};
    req_data   = {rv[3], rv[2], rv[1], rv[0]};
    bcast_req  = bq;
    bcast_data = bv;
    clr_err    = ce;
    dacdone    = (ack_at == cyc + 1) || spur;
    @(posedge CLK50MHZ);
    cyc++;
    if (!RST) model_reset();
    else model_edge();
    #1;
    chk_eq("data", 32'(data), 32'(e_data));
    chk_eq("address", 32'(address), 32'(e_addr));
    chk_eq("command", 32'(command), 32'(CMD_WR_UPD));
    chk_eq("dactrig", 32'(dactrig), 32'(e_trig));
    chk_eq("busy", 32'(busy), 32'(e_busy));
    chk_eq("done", 32'(done), 32'(e_done));
    chk_eq("done_addr", 32'(done_addr), 32'(e_daddr));
    chk_eq("err", 32'(err), 32'(e_err));
    if (dactrig === 1'b1) begin
      obs_q.push_back({address, data});
      obs_t.push_back(cyc);
      if (!hold) ack_at = cyc + lat;
    end
    if (done === 1'b1) dn_q.push_back(done_addr);
    foreach (rq[i]) rq[i] = 0;
    bq = 0; ce = 0; spur = 0;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    obs_q.delete(); obs_t.delete(); dn_q.delete(); exp_q.delete();
  endtask

  task automatic chk_log(input string tag);
    chk_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk_eq(tag, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic reset_pulse();
    RST = 1'b0; step(); RST = 1'b1; step();
    clear_logs();
  endtask

  initial begin
    foreach (rv[i]) rv[i] = '0;
    bv = '0; hold = 0; RST = 1'b0;
    model_reset();

    // reset held with random activity on every input
    repeat (6) begin
      foreach (rq[i]) begin rq[i] = 1'($urandom_range(0, 1)); rv[i] = DW'($urandom); end
      bq = 1'($urandom_range(0, 1)); bv = DW'($urandom);
      ce = 1'($urandom_range(0, 1)); spur = 1'($urandom_range(0, 1));
      step();
    end
    chk_eq("reset_no_trig", obs_q.size(), 0);
    RST = 1'b1;
    drain(3);
    clear_logs();

    // single channel, including request-to-trigger latency
    rq[2] = 1; rv[2] = 12'h800; step(); t0 = cyc;
    drain(20);
    exp_q.push_back({4'd2, 12'h800});
    chk_log("single");
    if (obs_t.size() > 0) chk_eq("single_latency", obs_t[0] - t0, 2);
    else chk_eq("single_latency", -1, 2);
    chk_eq("single_done_count", dn_q.size(), 1);
    if (dn_q.size() > 0) chk_eq("single_done_addr", 32'(dn_q[0]), 2);
    clear_logs();

    // round robin from a fresh pointer
    reset_pulse();
    foreach (rq[i]) begin rq[i] = 1; rv[i] = DW'(i + 1); end
    step(); drain(40);
    for (int i = 0; i < NCH; i++) exp_q.push_back({4'(i), DW'(i + 1)});
    chk_log("rr_all");
    clear_logs();
    rq[0] = 1; rv[0] = 12'h0A0; rq[3] = 1; rv[3] = 12'h0D0;
    step(); drain(30);
    exp_q.push_back({4'd0, 12'h0A0}); exp_q.push_back({4'd3, 12'h0D0});
    chk_log("rr_pair");
    clear_logs();

    // coalescing during a slow transaction
    lat = 12;
    rq[0] = 1; rv[0] = 12'h055; step(); drain(4);
    rq[1] = 1; rv[1] = 12'h100; step();
    rq[1] = 1; rv[1] = 12'h200; step();
    drain(40);
    exp_q.push_back({4'd0, 12'h055}); exp_q.push_back({4'd1, 12'h200});
    chk_log("coalesce");
    clear_logs();

    // broadcast supersedes a pending channel
    rq[0] = 1; rv[0] = 12'h066; step(); drain(4);
    rq[3] = 1; rv[3] = 12'h333; step();
    bq = 1; bv = 12'hFFE; step();
    drain(40);
    exp_q.push_back({4'd0, 12'h066}); exp_q.push_back({ADDR_ALL, 12'hFFE});
    chk_log("bcast");
    clear_logs();
    lat = 3;

    // timeout, then the queued channel still gets served
    hold = 1;
    rq[1] = 1; rv[1] = 12'h111; step(); drain(3);
    hold = 0;
    rq[2] = 1; rv[2] = 12'h222; step();
    drain(TMO + 20);
    exp_q.push_back({4'd1, 12'h111}); exp_q.push_back({4'd2, 12'h222});
    chk_log("timeout");
    chk_eq("timeout_err", 32'(err), 1);
    chk_eq("timeout_done_count", dn_q.size(), 1);
    if (dn_q.size() > 0) chk_eq("timeout_done_addr", 32'(dn_q[0]), 2);
    ce = 1; step();
    chk_eq("clr_err", 32'(err), 0);
    clear_logs();

    // reset while waiting; the engine's late completion must be ignored
    lat = 10;
    rq[0] = 1; rv[0] = 12'h777; step(); drain(4);
    RST = 1'b0; step(); RST = 1'b1;
    drain(20);
    exp_q.push_back({4'd0, 12'h777});
    chk_log("reset_wait");
    chk_eq("reset_wait_done_count", dn_q.size(), 0);
    clear_logs();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      foreach (rq[i]) begin rq[i] = ($urandom_range(0, 7) == 0); rv[i] = DW'($urandom); end
      bq   = ($urandom_range(0, 39) == 0); bv = DW'($urandom);
      ce   = ($urandom_range(0, 49) == 0);
      spur = ($urandom_range(0, 99) == 0);
      hold = ($urandom_range(0, 19) == 0);
      lat  = $urandom_range(1, 6);
      RST  = ($urandom_range(0, 499) != 0);
      step();
    end
    RST = 1'b1; hold = 0;
    drain(TMO + 40);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
